ball_renderer: RTL

Pixel-source stage directly upstream of vgaDriver. Keeps a square ball's position and velocity and advances the motion once per frame on the vSync assertion edge. Bounces the ball off the 640x480 active-area edges. For each row/column coordinate returned by vgaDriver, produces the registered RGB565 pixel that drives vgaDriver rgb_i.

---
 rtl/vga_pkg.sv | 36 +++
 rtl/ball_renderer_if.sv | 10 +
 rtl/ball_axis.sv | 48 ++++
 rtl/ball_renderer.sv | 120 ++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the ball renderer: RGB565 colours, default active
// area, FSM state encoding and the box-membership helper.
package vga_pkg;

  typedef logic [15:0] rgb565_t;

  localparam rgb565_t RED     = 16'hF800;
  localparam rgb565_t GREEN   = 16'h07E0;
  localparam rgb565_t BLUE    = 16'h001F;
  localparam rgb565_t YELLOW  = 16'hFFE0;
  localparam rgb565_t MAGENTA = 16'hF81F;
  localparam rgb565_t CYAN    = 16'h07FF;
  localparam rgb565_t BLACK   = 16'h0000;
  localparam rgb565_t WHITE   = 16'hFFFF;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  // state        | meaning
  // ST_WAIT_SYNC | idle, waiting for the vsync assertion edge
  // ST_MOVE_X    | advance / clamp the horizontal axis
  // ST_MOVE_Y    | advance / clamp the vertical axis
  // ST_HOLD      | frame handled, wait for vsync to deassert
  localparam logic [1:0] ST_WAIT_SYNC = 2'd0;
  localparam logic [1:0] ST_MOVE_X    = 2'd1;
  localparam logic [1:0] ST_MOVE_Y    = 2'd2;
  localparam logic [1:0] ST_HOLD      = 2'd3;

  // Unsigned wrap makes coordinates before the origin land far above size.
  function automatic logic in_span(input logic [15:0] coord,
                                   input logic [15:0] origin,
                                   input logic [15:0] size);
    return (coord - origin) < size;
  endfunction

endpackage

// File: rtl/ball_renderer_if.sv
// Pixel bus between vgaDriver (master) and the ball renderer (slave).
interface ball_renderer_if;
  logic        vsync;
  logic [15:0] row;
  logic [15:0] column;
  logic [15:0] rgb;

  modport master (output vsync, output row, output column, input rgb);
  modport slave  (input vsync, input row, input column, output rgb);
endinterface

// File: rtl/ball_axis.sv
// One motion axis: position and velocity registers with clamp-and-negate
// bounce handling, advanced once per step strobe.
module ball_axis
  import vga_pkg::*;
#(
  parameter int LIMIT    = 636,
  parameter int POS_INIT = 128,
  parameter int VEL_INIT = -2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        step_i,
  output logic [15:0] pos_o,
  output logic        bounce_o
);

  localparam logic signed [16:0] LIMIT17 = 17'(LIMIT);

  logic signed [15:0] vel;
  logic signed [16:0] nx;

  assign nx = $signed({1'b0, pos_o}) + $signed({vel[15], vel});

  // Step: clamp to [0, LIMIT]; the axis that hits reverses and flags a bounce.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pos_o    <= 16'(POS_INIT);
      vel      <= 16'(VEL_INIT);
      bounce_o <= 1'b0;
    end else begin
      bounce_o <= 1'b0;
      if (step_i) begin
        if (nx < 17'sd0) begin
          pos_o    <= 16'd0;
          vel      <= -vel;
          bounce_o <= 1'b1;
        end else if (nx > LIMIT17) begin
          pos_o    <= LIMIT17[15:0];
          vel      <= -vel;
          bounce_o <= 1'b1;
        end else begin
          pos_o <= nx[15:0];
        end
      end
    end
  end

endmodule

// File: rtl/ball_renderer.sv
// Ball renderer: vsync edge detect, per-frame motion FSM and registered
// RGB565 pixel compare. Build option BALL_BORDER_EN adds a green frame on
// the outermost active rows/columns (ball drawn on top of it).
module ball_renderer
  import vga_pkg::*;
#(
  parameter int      H_ACTIVE     = H_ACTIVE_DEF,
  parameter int      V_ACTIVE     = V_ACTIVE_DEF,
  parameter int      BALL_SIZE    = 4,
  parameter int      H_INIT       = 128,
  parameter int      V_INIT       = 128,
  parameter int      H_VEL_INIT   = -2,
  parameter int      V_VEL_INIT   = 2,
  parameter rgb565_t BALL_COLOR   = 16'hFFFF,
  parameter rgb565_t BG_COLOR     = 16'h0000,
  parameter logic    VSYNC_ACTIVE = 1'b0
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic           run_i,
  ball_renderer_if.slave vga,
  output logic [15:0]    ball_x_o,
  output logic [15:0]    ball_y_o,
  output logic           bounce_o
);

  localparam logic [15:0] SIZE16 = 16'(BALL_SIZE);
  localparam logic [15:0] H_ACT16 = 16'(H_ACTIVE);
  localparam logic [15:0] V_ACT16 = 16'(V_ACTIVE);

  logic [1:0] state;
  logic       vsync_q;
  logic       armed;
  logic       tick;
  logic       bounce_x, bounce_y;

  // armed is only set once an inactive vsync has been seen, so a pulse that
  // is already in progress when reset releases is not mistaken for an edge.
  assign tick = armed && (vsync_q != VSYNC_ACTIVE) && (vga.vsync == VSYNC_ACTIVE);

  // Register vsync for edge detection.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vsync_q <= ~VSYNC_ACTIVE;
      armed   <= 1'b0;
    end else begin
      vsync_q <= vga.vsync;
      if (vga.vsync != VSYNC_ACTIVE) armed <= 1'b1;
    end
  end

  // One motion update per frame; run_i is only looked at on the tick.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= ST_WAIT_SYNC;
    end else begin
      case (state)
        ST_WAIT_SYNC: if (tick) state <= run_i ? ST_MOVE_X : ST_HOLD;
        ST_MOVE_X:    state <= ST_MOVE_Y;
        ST_MOVE_Y:    state <= ST_HOLD;
        default:      if (vga.vsync != VSYNC_ACTIVE) state <= ST_WAIT_SYNC;
      endcase
    end
  end

  ball_axis #(
    .LIMIT   (H_ACTIVE - BALL_SIZE),
    .POS_INIT(H_INIT),
    .VEL_INIT(H_VEL_INIT)
  ) u_axis_x (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .step_i  (state == ST_MOVE_X),
    .pos_o   (ball_x_o),
    .bounce_o(bounce_x)
  );

  ball_axis #(
    .LIMIT   (V_ACTIVE - BALL_SIZE),
    .POS_INIT(V_INIT),
    .VEL_INIT(V_VEL_INIT)
  ) u_axis_y (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .step_i  (state == ST_MOVE_Y),
    .pos_o   (ball_y_o),
    .bounce_o(bounce_y)
  );

  assign bounce_o = bounce_x | bounce_y;

  logic    in_active;
  logic    hit;
  rgb565_t pix;

  assign in_active = (vga.column < H_ACT16) && (vga.row < V_ACT16);
  assign hit = in_active && in_span(vga.column, ball_x_o, SIZE16)
                         && in_span(vga.row, ball_y_o, SIZE16);

  // Pixel colour select: ball over optional border over background.
  always_comb begin
    pix = BG_COLOR;
    if (hit) begin
      pix = BALL_COLOR;
    end
`ifdef BALL_BORDER_EN
    else if (in_active && (vga.column == 16'd0 || vga.column == H_ACT16 - 16'd1 ||
                           vga.row == 16'd0 || vga.row == V_ACT16 - 16'd1)) begin
      pix = GREEN;
    end
`endif
  end

  // Register the pixel: one clock from row/column to rgb.
  always_ff @(posedge clk_i) begin
    if (reset_i) vga.rgb <= BG_COLOR;
    else         vga.rgb <= pix;
  end

endmodule
